// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Parametrised UART transmitter with an input FIFO. Words enter
//            through a valid/ready handshake, are queued, and are serialised
//            LSB-first as start / data / optional parity / stop bits. Frames
//            run back-to-back with no idle gap while data is queued.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   system clock, all state on rising edge
//   rst            in   asynchronous active-high reset
//   i_tx_data      in   word to send (DATA_BITS wide)
//   i_tx_valid     in   i_tx_data is valid this cycle
//   o_tx_ready     out  FIFO can accept a word (not full)
//   o_tx           out  serial line, idle high, registered
//   o_busy         out  high while the transmitter is not idle
//   o_frame_done   out  one-cycle pulse when the last stop bit ends
//   o_fifo_count   out  words currently queued
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          i_tx_data,
    input  logic                          i_tx_valid,
    output logic                          o_tx_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic                          o_frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int DIV    = CLK_FREQ / BAUD;
    localparam int CNT_W  = $clog2(DIV);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam int IDX_W  = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0]  c_BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  c_DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  c_STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [FCNT_W-1:0] c_DEPTH     = FCNT_W'(FIFO_DEPTH);
    localparam logic              c_HAS_PAR   = (PARITY != 0);
    localparam logic              c_ODD_PAR   = (PARITY == 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [FCNT_W-1:0]    r_count;

    // ------------------------------------------------------------------------
    // Transmitter state
    // ------------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_baud;
    logic [IDX_W-1:0]     r_idx;     // data bit index, reused as stop bit index
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_frame_done;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_baud_end;
    logic                 w_stop_end;
    logic [DATA_BITS-1:0] w_head;

    assign w_empty    = (r_count == '0);
    assign w_push     = i_tx_valid && o_tx_ready;
    assign w_baud_end = (r_baud == c_BAUD_LAST);
    assign w_stop_end = (r_state == S_STOP) && w_baud_end && (r_idx == c_STOP_LAST);
    assign w_head     = r_mem[r_rd_ptr];

    // A new word is taken either from idle or on the very edge that ends the
    // last stop bit, which is what makes consecutive frames gapless.
    assign w_pop = !w_empty && ((r_state == S_IDLE) || w_stop_end);

    assign o_tx_ready   = (r_count != c_DEPTH);
    assign o_tx         = r_tx;
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = r_frame_done;
    assign o_fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FCNT_W'(1);
                2'b01:   r_count <= r_count - FCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_tx         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                    if (w_pop) begin
                        // Parity is computed from the whole word at load time,
                        // before shifting destroys it.
                        r_shift <= w_head;
                        r_par   <= (^w_head) ^ c_ODD_PAR;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_idx   <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_idx == c_DATA_LAST) begin
                            r_idx <= '0;
                            if (c_HAS_PAR) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_idx   <= '0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_idx == c_STOP_LAST) begin
                            r_idx        <= '0;
                            r_frame_done <= 1'b1;
                            if (w_pop) begin
                                r_shift <= w_head;
                                r_par   <= (^w_head) ^ c_ODD_PAR;
                                r_state <= S_START;
                                r_tx    <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo. Four instances share a
//            clock and reset: 8N1, 8E1, 8O1 and 7N2, all at 16 clocks per bit
//            with a 4-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic             clk;
    logic             rst;
    logic [3:0]       v;
    logic [8:0]       d;
    logic [3:0]       tx_w;
    logic [3:0]       busy_w;
    logic [3:0]       fd_w;
    logic [3:0]       rdy_w;
    logic [3:0][2:0]  cnt_w;

    int errors;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .i_tx_data(d[7:0]), .i_tx_valid(v[0]),
        .o_tx_ready(rdy_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]),
        .o_frame_done(fd_w[0]), .o_fifo_count(cnt_w[0]));

    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .i_tx_data(d[7:0]), .i_tx_valid(v[1]),
        .o_tx_ready(rdy_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]),
        .o_frame_done(fd_w[1]), .o_fifo_count(cnt_w[1]));

    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .i_tx_data(d[7:0]), .i_tx_valid(v[2]),
        .o_tx_ready(rdy_w[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]),
        .o_frame_done(fd_w[2]), .o_fifo_count(cnt_w[2]));

    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .clk(clk), .rst(rst), .i_tx_data(d[6:0]), .i_tx_valid(v[3]),
        .o_tx_ready(rdy_w[3]), .o_tx(tx_w[3]), .o_busy(busy_w[3]),
        .o_frame_done(fd_w[3]), .o_fifo_count(cnt_w[3]));

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one word into instance s and check the two-clock start latency.
    task automatic send(input int s, input logic [8:0] data, input string name);
        v[s] = 1'b1;
        d    = data;
        step();
        v[s] = 1'b0;
        checks++;
        if (cnt_w[s] !== 3'd1 || tx_w[s] !== 1'b1) begin
            errors++;
            $display("FAIL %s push: count=%0d tx=%b, required count=1 tx=1", name, cnt_w[s], tx_w[s]);
        end
        step();
        checks++;
        if (tx_w[s] !== 1'b0 || busy_w[s] !== 1'b1 || cnt_w[s] !== 3'd0) begin
            errors++;
            $display("FAIL %s start: tx=%b busy=%b count=%0d, required tx=0 busy=1 count=0",
                     name, tx_w[s], busy_w[s], cnt_w[s]);
        end
    endtask

    // Follow one frame clock by clock from line offset c0 (0 = first clock of
    // the start bit), then check the frame_done pulse and decode the mid-bit
    // samples as a receiver would.
    task automatic run_frame(input int s, input logic [8:0] data, input int dbits,
                             input int par, input int sbits, input int c0,
                             input string name);
        logic [15:0] exp_bits;
        logic [15:0] rx;
        logic [8:0]  word;
        logic        p;
        int          n;
        exp_bits = '0;
        rx       = '0;
        p        = 1'b0;
        for (int i = 0; i < dbits; i++) begin
            exp_bits[1 + i] = data[i];
            p = p ^ data[i];
        end
        n = 1 + dbits;
        if (par != 0) begin
            exp_bits[n] = (par == 1) ? ~p : p;
            n++;
        end
        for (int j = 0; j < sbits; j++) begin
            exp_bits[n] = 1'b1;
            n++;
        end
        for (int c = c0; c < n * 16; c++) begin
            if (c != c0) step();
            checks++;
            if (tx_w[s] !== exp_bits[c / 16]) begin
                errors++;
                $display("FAIL %s line clk %0d: tx=%b, required %b", name, c, tx_w[s], exp_bits[c / 16]);
            end
            if (c > 0) begin
                checks++;
                if (fd_w[s] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early frame_done at clk %0d: got %b, required 0", name, c, fd_w[s]);
                end
            end
            if ((c % 16) == 8) rx[c / 16] = tx_w[s];
        end
        step();
        checks++;
        if (fd_w[s] !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_done at clk %0d: got %b, required 1", name, n * 16, fd_w[s]);
        end
        word = '0;
        for (int i = 0; i < dbits; i++) word[i] = rx[1 + i];
        checks++;
        if (word !== (data & ((9'd1 << dbits) - 9'd1))) begin
            errors++;
            $display("FAIL %s loopback data: got %h, required %h", name, word, data);
        end
        if (par != 0) begin
            checks++;
            if (rx[1 + dbits] !== exp_bits[1 + dbits]) begin
                errors++;
                $display("FAIL %s loopback parity: got %b, required %b", name, rx[1 + dbits], exp_bits[1 + dbits]);
            end
        end
    endtask

    // Just after the final frame_done edge with nothing queued: idle again.
    task automatic check_idle(input int s, input string name);
        checks++;
        if (tx_w[s] !== 1'b1 || busy_w[s] !== 1'b0 || cnt_w[s] !== 3'd0) begin
            errors++;
            $display("FAIL %s end: tx=%b busy=%b count=%0d, required tx=1 busy=0 count=0",
                     name, tx_w[s], busy_w[s], cnt_w[s]);
        end
        step();
        checks++;
        if (fd_w[s] !== 1'b0 || busy_w[s] !== 1'b0 || tx_w[s] !== 1'b1) begin
            errors++;
            $display("FAIL %s after end: frame_done=%b busy=%b tx=%b, required 0 0 1",
                     name, fd_w[s], busy_w[s], tx_w[s]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v   = '0;
        d   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            for (int s = 0; s < 4; s++) begin
                checks++;
                if (tx_w[s] !== 1'b1 || rdy_w[s] !== 1'b1 || busy_w[s] !== 1'b0 ||
                    cnt_w[s] !== 3'd0 || fd_w[s] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset dut%0d: tx=%b ready=%b busy=%b count=%0d fd=%b, required 1 1 0 0 0",
                             s, tx_w[s], rdy_w[s], busy_w[s], cnt_w[s], fd_w[s]);
                end
            end
            step();
        end
    endtask

    task automatic test_8n1();
        send(0, 9'h053, "8n1_53");
        run_frame(0, 9'h053, 8, 0, 1, 0, "8n1_53");
        check_idle(0, "8n1_53");
    endtask

    task automatic test_parity();
        send(1, 9'h06E, "8e1_6e");
        run_frame(1, 9'h06E, 8, 2, 1, 0, "8e1_6e");
        check_idle(1, "8e1_6e");
        send(2, 9'h06E, "8o1_6e");
        run_frame(2, 9'h06E, 8, 1, 1, 0, "8o1_6e");
        check_idle(2, "8o1_6e");
    endtask

    task automatic test_back_to_back();
        bit seen;
        v[0] = 1'b1;
        d    = 9'h001;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rdy_w[0] !== 1'b1) begin
                errors++;
                $display("FAIL b2b ready before push %0d: got %b, required 1", i + 1, rdy_w[0]);
            end
            step();
            d = d + 9'd1;
        end
        checks++;
        if (cnt_w[0] !== 3'd4 || rdy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b full: count=%0d ready=%b, required count=4 ready=0", cnt_w[0], rdy_w[0]);
        end
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (fd_w[0] === 1'b1) begin
                seen = 1'b1;
            end else begin
                checks++;
                if (rdy_w[0] !== 1'b0 || cnt_w[0] !== 3'd4) begin
                    errors++;
                    $display("FAIL b2b held full: ready=%b count=%0d, required ready=0 count=4", rdy_w[0], cnt_w[0]);
                end
                step();
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b first frame_done: got none within 300 clocks, required one");
        end
        checks++;
        if (cnt_w[0] !== 3'd3 || rdy_w[0] !== 1'b1 || tx_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b first gap: count=%0d ready=%b tx=%b, required 3 1 0", cnt_w[0], rdy_w[0], tx_w[0]);
        end
        step();
        v[0] = 1'b0;
        checks++;
        if (cnt_w[0] !== 3'd4) begin
            errors++;
            $display("FAIL b2b push 06: count=%0d, required 4", cnt_w[0]);
        end
        run_frame(0, 9'h002, 8, 0, 1, 1, "b2b_02");
        for (int k = 3; k <= 6; k++) begin
            checks++;
            if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
                errors++;
                $display("FAIL b2b gap before %0d: tx=%b busy=%b, required tx=0 busy=1", k, tx_w[0], busy_w[0]);
            end
            run_frame(0, 9'(k), 8, 0, 1, 0, "b2b");
        end
        check_idle(0, "b2b");
    endtask

    task automatic test_7n2();
        send(3, 9'h055, "7n2_55");
        run_frame(3, 9'h055, 7, 0, 2, 0, "7n2_55");
        check_idle(3, "7n2_55");
    endtask

    task automatic test_reset_midframe();
        v[0] = 1'b1;
        d    = 9'h0A5;
        step();
        d = 9'h03C;
        step();
        v[0] = 1'b0;
        // Now on the first clock of the start bit of 0xA5; line bit 4 is data bit 3.
        repeat (70) step();
        checks++;
        if (tx_w[0] !== 1'b0 || cnt_w[0] !== 3'd1) begin
            errors++;
            $display("FAIL midreset before: tx=%b count=%0d, required tx=0 count=1", tx_w[0], cnt_w[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (tx_w[0] !== 1'b1 || cnt_w[0] !== 3'd0 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset async: tx=%b count=%0d busy=%b ready=%b, required 1 0 0 1",
                     tx_w[0], cnt_w[0], busy_w[0], rdy_w[0]);
        end
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step();
            checks++;
            if (tx_w[0] !== 1'b1 || fd_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
                errors++;
                $display("FAIL midreset idle clk %0d: tx=%b fd=%b busy=%b, required 1 0 0",
                         c, tx_w[0], fd_w[0], busy_w[0]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        v      = '0;
        d      = '0;
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_7n2();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 9600-baud serializer. It takes words through a valid/ready handshake into a small FIFO. It serializes them LSB-first with configurable data width, parity and stop bits, and sends frames back-to-back with no idle gap while data is queued. Its tx output feeds the existing receiver for loopback checks.

Parameters:
CLK_FREQ, 12000000, system clock frequency in Hz
BAUD, 9600, line rate; DIV = CLK_FREQ/BAUD clocks per bit (integer division, DIV >= 2)
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, 1 or 2
FIFO_DEPTH, 4, input FIFO entries, power of 2, >= 2

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
tx_data  in  DATA_BITS  word to send
tx_valid  in  1  tx_data is valid this cycle
tx_ready  out  1  FIFO can accept a word (= not full)
tx  out  1  serial line, idle high, registered
busy  out  1  high while state != IDLE
frame_done  out  1  one-cycle pulse when the last stop bit ends
fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently queued

Behaviour:
- Reset (async assert, sync release): tx=1, busy=0, tx_ready=1, frame_done=0, fifo_count=0. FIFO pointers cleared, state=IDLE, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame. tx returns high immediately. No frame_done is produced and queued data is discarded.
- Push: accepted on a rising edge with tx_valid && tx_ready. A push while full is ignored and does not corrupt the FIFO.
- Pop and push in the same cycle are both allowed and leave fifo_count unchanged.
- Baud counter: width $clog2(DIV). It counts 0..DIV-1 and restarts at 0 on each bit boundary and at frame start. Each line bit lasts exactly DIV clocks.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If the FIFO is non-empty, on the next edge pop the head into the shift register, go to START and drive tx=0.
- START: after DIV clocks go to DATA and drive tx=shift[0].
- DATA: shift right each bit, LSB first. After DATA_BITS bits go to PARITY if PARITY != 0, else go to STOP.
- PARITY: bit = XOR of all data bits for even parity, inverted for odd parity. Lasts DIV clocks, then go to STOP.
- STOP: tx=1 for STOP_BITS*DIV clocks.
- End of STOP: frame_done=1 for exactly one cycle. If the FIFO is non-empty, pop in the same edge and go to START (tx=0 with no idle clock). Otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV clocks.
- Latency from an accepted push into an empty FIFO with state IDLE: fifo_count=1 on the next edge, pop plus tx falling on the following edge (2 clocks).
- tx_ready = (fifo_count != FIFO_DEPTH), combinational from registered count. The shift register holds one extra word in flight, so FIFO_DEPTH+1 words can be outstanding.
- Data bits above DATA_BITS do not exist. tx_data width is exactly DATA_BITS.
- busy deasserts on the same edge that enters IDLE. frame_done and busy-low can coincide.

Test Plan:
1. Hold rst=1 for 3 clocks, then release -> tx=1, tx_ready=1, busy=0, fifo_count=0, frame_done never pulses.
2. DIV=16 (CLK_FREQ=16, BAUD=1), 8N1, push 0x53 -> tx sequence 0,1,1,0,0,1,0,1,0,1, each 16 clocks. frame_done pulses exactly 160 clocks after tx falls. busy=0 the following cycle.
3. DIV=16, PARITY=2, push 0x6E (five ones) -> parity bit 1. Same with PARITY=1 -> parity bit 0. Frame is 176 clocks. Loopback receiver configured 8E1 returns 0x6E.
4. DIV=16, FIFO_DEPTH=4, tx_valid held high with 0x01..0x07 -> five words accepted (0x01 in flight, 0x02..0x05 queued). tx_ready low until the first frame_done, then 0x06 accepted. Frames are contiguous with no idle-high gap between stop bit and next start bit.
5. DATA_BITS=7, STOP_BITS=2, PARITY=0, push 7'h55 -> 0,1,0,1,0,1,0,1,1,1 on the line. Stop phase is 32 clocks, total 160 clocks.
6. DIV=16, push 0xA5 and 0x3C, assert rst during data bit 3 of the first frame -> tx=1 within the same cycle (async). fifo_count=0, no frame_done. After release the line stays idle until a new push.
